// File: rtl/uart_boot_loader.sv
// UART 8N1 program loader: hunts for 0xA5, takes a 16-bit LE word count, then streams
// LE 32-bit words into RAM from address 0. Optional trailing XOR checksum: LOADER_CHECKSUM_EN.
module uart_boot_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_rst,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

  // rx is asynchronous; two flops before anything looks at it
  logic rx_m, rx_s;
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  rx_state_t        rx_state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       rx_byte;
  logic             byte_valid, frame_err;

  always_ff @(posedge clk) begin
    byte_valid <= 1'b0;
    frame_err  <= 1'b0;
    if (rst) begin
      rx_state <= RX_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      rx_byte  <= '0;
    end else begin
      case (rx_state)
        RX_IDLE: begin
          cnt <= '0;
          if (!rx_s) rx_state <= RX_START;
        end
        RX_START: begin
          if (cnt == HALF_M1) begin
            cnt      <= '0;
            bit_idx  <= '0;
            rx_state <= rx_s ? RX_IDLE : RX_DATA;
          end else cnt <= cnt + 1'b1;
        end
        RX_DATA: begin
          if (cnt == FULL_M1) begin
            cnt     <= '0;
            rx_byte <= {rx_s, rx_byte[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) rx_state <= RX_STOP;
          end else cnt <= cnt + 1'b1;
        end
        default: begin
          if (cnt == FULL_M1) begin
            cnt      <= '0;
            rx_state <= RX_IDLE;
            if (rx_s) byte_valid <= 1'b1;
            else      frame_err  <= 1'b1;
          end else cnt <= cnt + 1'b1;
        end
      endcase
    end
  end

  typedef enum logic [2:0] {S_SYNC, S_LEN0, S_LEN1, S_DATA, S_CSUM, S_DONE, S_ERR} state_t;
  state_t      state;
  logic [7:0]  len_lo;
  logic [16:0] words_left;
  logic [1:0]  byte_idx;
  logic [23:0] acc;
  logic [16:0] n_words;

  assign n_words = {1'b0, rx_byte, len_lo};

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum;
  always_ff @(posedge clk) begin
    if (rst || (byte_valid && state == S_SYNC))
      csum <= '0;
    else if (byte_valid && (state == S_LEN0 || state == S_LEN1 || state == S_DATA))
      csum <= csum ^ rx_byte;
  end
`endif

  always_ff @(posedge clk) begin
    mem_we <= 1'b0;
    if (rst) begin
      state      <= S_SYNC;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      core_rst   <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      len_lo     <= '0;
      words_left <= '0;
      byte_idx   <= '0;
      acc        <= '0;
    end else begin
      // address advances the cycle after each write; wraps harmlessly after a full image
      if (mem_we) mem_addr <= mem_addr + 1'b1;
      if (frame_err && state != S_DONE && state != S_ERR) begin
        state <= S_ERR;
        err   <= 1'b1;
        busy  <= 1'b0;
      end else if (byte_valid) begin
        case (state)
          S_SYNC: if (rx_byte == 8'hA5) state <= S_LEN0;
          S_LEN0: begin
            len_lo <= rx_byte;
            state  <= S_LEN1;
          end
          S_LEN1: begin
            byte_idx <= '0;
            if (n_words == '0) begin
`ifdef LOADER_CHECKSUM_EN
              state    <= S_CSUM;
`else
              state    <= S_DONE;
              done     <= 1'b1;
              core_rst <= 1'b0;
`endif
            end else if (n_words > MAX_WORDS) begin
              state <= S_ERR;
              err   <= 1'b1;
            end else begin
              state      <= S_DATA;
              busy       <= 1'b1;
              words_left <= n_words;
            end
          end
          S_DATA: begin
            byte_idx <= byte_idx + 1'b1;
            acc      <= {rx_byte, acc[23:8]};
            if (byte_idx == 2'd3) begin
              mem_we     <= 1'b1;
              mem_wdata  <= {rx_byte, acc};
              words_left <= words_left - 1'b1;
              if (words_left == 17'd1) begin
`ifdef LOADER_CHECKSUM_EN
                state    <= S_CSUM;
`else
                state    <= S_DONE;
                busy     <= 1'b0;
                done     <= 1'b1;
                core_rst <= 1'b0;
`endif
              end
            end
          end
`ifdef LOADER_CHECKSUM_EN
          S_CSUM: begin
            busy <= 1'b0;
            if (rx_byte == csum) begin
              state    <= S_DONE;
              done     <= 1'b1;
              core_rst <= 1'b0;
            end else begin
              state <= S_ERR;
              err   <= 1'b1;
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed bench for uart_boot_loader at CLKS_PER_BIT=16; follows LOADER_CHECKSUM_EN if defined.
module tb_uart_boot_loader;
  localparam int CPB    = 16;
  localparam int ADDR_W = 8;
`ifdef LOADER_CHECKSUM_EN
  localparam logic CS_EN = 1'b1;
`else
  localparam logic CS_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst, rx;
  logic              mem_we, core_rst, busy, done, err;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  uart_boot_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .rx(rx), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .core_rst(core_rst), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // write log, captured with done as seen in the write cycle
  int                wr_n = 0;
  logic [ADDR_W-1:0] wr_addr [64];
  logic [31:0]       wr_data [64];
  logic              wr_done [64];
  always @(posedge clk) begin
    if (mem_we && wr_n < 64) begin
      wr_addr[wr_n] <= mem_addr;
      wr_data[wr_n] <= mem_wdata;
      wr_done[wr_n] <= done;
      wr_n          <= wr_n + 1;
    end
  end

  int total = 0;
  int bad   = 0;
  int base;
  logic [7:0] cs;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    cs = cs ^ b;
  endtask

  task automatic start_frame();
    send_byte(8'hA5);
    cs = 8'h00;
  endtask

  task automatic end_frame();
`ifdef LOADER_CHECKSUM_EN
    send_byte(cs);
`else
    @(negedge clk);
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    base = wr_n;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_we"},    {31'd0, mem_we},   32'd0);
    check({tag, "_addr"},  {24'd0, mem_addr}, 32'd0);
    check({tag, "_wdata"}, mem_wdata,         32'd0);
    check({tag, "_crst"},  {31'd0, core_rst}, 32'd1);
    check({tag, "_busy"},  {31'd0, busy},     32'd0);
    check({tag, "_done"},  {31'd0, done},     32'd0);
    check({tag, "_err"},   {31'd0, err},      32'd0);
  endtask

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    cs  = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_state("rst");
    rst = 1'b0;
    idle(20);
    base = wr_n;

    // normal two-word load
    start_frame();
    send_byte(8'h02); send_byte(8'h00);
    check("norm_busy", {31'd0, busy}, 32'd1);
    check("norm_crst_mid", {31'd0, core_rst}, 32'd1);
    send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
    send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
    end_frame();
    idle(5);
    check("norm_nwr", wr_n - base, 2);
    check("norm_a0", {24'd0, wr_addr[base]}, 32'd0);
    check("norm_d0", wr_data[base], 32'h12345678);
    check("norm_a1", {24'd0, wr_addr[base+1]}, 32'd1);
    check("norm_d1", wr_data[base+1], 32'hDEADBEEF);
    check("norm_done_at_we1", {31'd0, wr_done[base+1]}, {31'd0, ~CS_EN});
    check("norm_done", {31'd0, done}, 32'd1);
    check("norm_crst", {31'd0, core_rst}, 32'd0);
    check("norm_err", {31'd0, err}, 32'd0);
    check("norm_busy_end", {31'd0, busy}, 32'd0);
    check("norm_addr", {24'd0, mem_addr}, 32'd2);
    send_byte(8'hA5); send_byte(8'h01);
    idle(5);
    check("norm_after_done", {30'd0, done, err}, 32'd2);

    // glitch on rx and sync hunt
    do_reset();
    rx = 1'b0;
    repeat (3) @(negedge clk);
    idle(40);
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h3C);
    check("hunt_idle", {29'd0, busy, done, err}, 32'd0);
    start_frame();
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h04); send_byte(8'h03); send_byte(8'h02); send_byte(8'h01);
    end_frame();
    idle(5);
    check("hunt_nwr", wr_n - base, 1);
    check("hunt_a0", {24'd0, wr_addr[base]}, 32'd0);
    check("hunt_d0", wr_data[base], 32'h01020304);
    check("hunt_done", {31'd0, done}, 32'd1);

    // empty image
    do_reset();
    start_frame();
    send_byte(8'h00); send_byte(8'h00);
    end_frame();
    idle(5);
    check("empty_nwr", wr_n - base, 0);
    check("empty_done", {31'd0, done}, 32'd1);
    check("empty_crst", {31'd0, core_rst}, 32'd0);

    // oversize N=257
    do_reset();
    start_frame();
    send_byte(8'h01); send_byte(8'h01);
    idle(5);
    check("over_err", {31'd0, err}, 32'd1);
    check("over_crst", {31'd0, core_rst}, 32'd1);
    check("over_busy", {31'd0, busy}, 32'd0);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    idle(5);
    check("over_nwr", wr_n - base, 0);
    check("over_done", {31'd0, done}, 32'd0);

    // N=256 is the largest legal image
    do_reset();
    start_frame();
    send_byte(8'h00); send_byte(8'h01);
    idle(5);
    check("max_busy", {31'd0, busy}, 32'd1);
    check("max_err", {31'd0, err}, 32'd0);

    // framing error on 3rd data byte
    do_reset();
    start_frame();
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33, 1'b0);
    idle(40);
    check("ferr_err", {31'd0, err}, 32'd1);
    check("ferr_busy", {31'd0, busy}, 32'd0);
    check("ferr_crst", {31'd0, core_rst}, 32'd1);
    send_byte(8'h44); send_byte(8'h55); send_byte(8'h66);
    send_byte(8'h77); send_byte(8'h88);
    idle(5);
    check("ferr_nwr", wr_n - base, 0);
    check("ferr_done", {31'd0, done}, 32'd0);

    // reset mid-frame, then a fresh load from address 0
    do_reset();
    start_frame();
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    send_byte(8'h55); send_byte(8'h66);
    check("mid_nwr", wr_n - base, 1);
    check("mid_d0", wr_data[base], 32'h44332211);
    check("mid_addr", {24'd0, mem_addr}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_reset_state("mid_rst");
    rst = 1'b0;
    idle(5);
    base = wr_n;
    start_frame();
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
    end_frame();
    idle(5);
    check("mid2_nwr", wr_n - base, 1);
    check("mid2_a0", {24'd0, wr_addr[base]}, 32'd0);
    check("mid2_d0", wr_data[base], 32'hDDCCBBAA);
    check("mid2_done", {31'd0, done}, 32'd1);

`ifdef LOADER_CHECKSUM_EN
    // checksum covers both length bytes and data: 01^00^01^02^03^04 = 05
    do_reset();
    start_frame();
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    send_byte(8'h05);
    idle(5);
    check("cs_ok_done", {31'd0, done}, 32'd1);
    check("cs_ok_nwr", wr_n - base, 1);
    do_reset();
    start_frame();
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    send_byte(8'h04);
    idle(5);
    check("cs_bad_nwr", wr_n - base, 1);
    check("cs_bad_d0", wr_data[base], 32'h04030201);
    check("cs_bad_err", {31'd0, err}, 32'd1);
    check("cs_bad_crst", {31'd0, core_rst}, 32'd1);
    check("cs_bad_done", {31'd0, done}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
